la_cmd_responder: RTL

//  User-area responder for the management core's logic-analyzer (LA) command link. Firmware posts a

---
 rtl/la_cmd_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/la_cmd_responder.sv
// rtl/la_cmd_responder.sv - user-area responder for the management LA command link
//
// Purpose:
//   Firmware posts a command word on la_data_in and toggles the request bit;
//   this block executes the command and returns result, status and a toggled
//   ack on la_data_out. WRITE_CHECK drives a 16-bit checkpoint code onto the
//   user io pins so benches can follow firmware progress.
//   Optional feature macro: LA_CMD_PARITY_EN (even parity over la_data_in[39:0]
//   carried in la_data_in[62]; a mismatch is acked as an error, not executed).
//
// Ports:
//   clock       in  1     single clock
//   resetb      in  1     synchronous, active-low reset
//   la_data_in  in  64    [31:0] arg, [39:32] opcode, [62] parity, [63] req toggle
//   la_oenb     in  64    active-low LA output enable; bit 63 gates the request
//   la_data_out out 64    [31:0] result, [39:32] opcode, [40] err, [62:48] cmd_cnt, [63] ack
//   io_out      out IO_W  checkpoint on [CHECK_LSB+15:CHECK_LSB], zero elsewhere
//   io_oeb      out IO_W  0 on the checkpoint field, 1 elsewhere

module la_cmd_responder #(
  parameter int          CHECK_LSB   = 16,
  parameter int          IO_W        = 38,
  parameter logic [15:0] RESET_CHECK = 16'h0000
) (
  input  logic            clock,
  input  logic            resetb,
  input  logic [63:0]     la_data_in,
  input  logic [63:0]     la_oenb,
  output logic [63:0]     la_data_out,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [7:0] OP_WRITE_CHECK = 8'h01;
  localparam logic [7:0] OP_ECHO        = 8'h02;
  localparam logic [7:0] OP_ADD         = 8'h03;
  localparam logic [7:0] OP_READ_CNT    = 8'h04;
  localparam logic [7:0] OP_CLEAR       = 8'h05;

  localparam logic [IO_W-1:0] FIELD_ONES = {{(IO_W-16){1'b0}}, 16'hFFFF};

  state_t      r_state;
  state_t      w_state_next;
  logic        w_take;

  // input stage
  logic        r_req_in;
  logic        r_oenb_req;
  logic [7:0]  r_opcode_in;
  logic [31:0] r_arg_in;

  // latched command and architectural state
  logic        r_req_seen;
  logic [7:0]  r_opcode;
  logic [31:0] r_arg;
  logic [31:0] r_acc;
  logic [14:0] r_cnt;
  logic [15:0] r_check;
  logic [31:0] r_result;
  logic        r_err;
  logic        r_clear;
  logic        r_wr_check;
  logic [63:0] r_out;

  // execute-stage combinational results
  logic        w_cmd_ok;
  logic [31:0] w_result;
  logic        w_err;
  logic [31:0] w_acc_next;
  logic        w_do_clear;
  logic        w_do_check;
  logic [14:0] w_cnt_next;

`ifdef LA_CMD_PARITY_EN
  logic        r_par_in;
  logic        r_par_bad;
  logic        w_unused_bits;
  assign w_unused_bits = ^{la_oenb[62:0], la_data_in[61:40]};
`else
  logic        w_unused_bits;
  assign w_unused_bits = ^{la_oenb[62:0], la_data_in[62:40]};
`endif

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    case (r_state)
      ST_ARM:  w_state_next = ST_IDLE;
      ST_IDLE: begin
        // a request held off by oenb stays pending until oenb drops
        if ((r_req_in != r_req_seen) && !r_oenb_req) begin
          w_take       = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_ARM;
    endcase
  end

  always_comb begin
    w_result   = 32'h0;
    w_err      = 1'b0;
    w_acc_next = r_acc;
    w_do_clear = 1'b0;
    w_do_check = 1'b0;
`ifdef LA_CMD_PARITY_EN
    w_cmd_ok   = !r_par_bad;
`else
    w_cmd_ok   = 1'b1;
`endif
    if (!w_cmd_ok) begin
      w_err = 1'b1;
    end else begin
      case (r_opcode)
        OP_WRITE_CHECK: begin
          w_result   = {16'h0, r_arg[15:0]};
          w_do_check = 1'b1;
        end
        OP_ECHO: w_result = r_arg;
        OP_ADD: begin
          w_acc_next = r_acc + r_arg;
          w_result   = w_acc_next;
        end
        OP_READ_CNT: w_result = {17'h0, r_cnt};
        OP_CLEAR: begin
          w_acc_next = 32'h0;
          w_do_clear = 1'b1;
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  assign w_cnt_next = r_clear ? 15'h0 : (r_cnt + 15'd1);

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state     <= ST_ARM;
      r_req_in    <= 1'b0;
      r_oenb_req  <= 1'b0;
      r_opcode_in <= 8'h0;
      r_arg_in    <= 32'h0;
      r_req_seen  <= 1'b0;
      r_opcode    <= 8'h0;
      r_arg       <= 32'h0;
      r_acc       <= 32'h0;
      r_cnt       <= 15'h0;
      r_check     <= RESET_CHECK;
      r_result    <= 32'h0;
      r_err       <= 1'b0;
      r_clear     <= 1'b0;
      r_wr_check  <= 1'b0;
      r_out       <= 64'h0;
`ifdef LA_CMD_PARITY_EN
      r_par_in    <= 1'b0;
      r_par_bad   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_req_in    <= la_data_in[63];
      r_oenb_req  <= la_oenb[63];
      r_opcode_in <= la_data_in[39:32];
      r_arg_in    <= la_data_in[31:0];
`ifdef LA_CMD_PARITY_EN
      r_par_in    <= la_data_in[62];
`endif
      case (r_state)
        ST_ARM: begin
          // adopt whatever req level is present now, so a req already set
          // across reset release is not mistaken for a new command
          r_req_seen <= la_data_in[63];
        end
        ST_IDLE: begin
          if (w_take) begin
            r_req_seen <= r_req_in;
            r_opcode   <= r_opcode_in;
            r_arg      <= r_arg_in;
`ifdef LA_CMD_PARITY_EN
            r_par_bad  <= ((^{r_opcode_in, r_arg_in}) != r_par_in);
`endif
          end
        end
        ST_EXEC: begin
          r_result   <= w_result;
          r_err      <= w_err;
          r_acc      <= w_acc_next;
          r_clear    <= w_do_clear;
          r_wr_check <= w_do_check;
        end
        ST_RESP: begin
          r_cnt <= w_cnt_next;
          // checkpoint changes on the same edge the ack is published
          if (r_clear) begin
            r_check <= RESET_CHECK;
          end else if (r_wr_check) begin
            r_check <= r_result[15:0];
          end
          r_out <= {r_req_seen, w_cnt_next, 7'h0, r_err, r_opcode, r_result};
        end
        default: ;
      endcase
    end
  end

  assign la_data_out = r_out;
  assign io_out      = {{(IO_W-16){1'b0}}, r_check} << CHECK_LSB;
  assign io_oeb      = ~(FIELD_ONES << CHECK_LSB);

endmodule
